// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: opcodes, R-type funct codes, ALU control
// codes and branch-operand bypass select codes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b011;
  localparam logic [2:0] ALU_NOR  = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU control decoder: maps the ID/EX opcode and funct field to a 3-bit ALU
// control. Anything not explicitly recognised (JR, J, JAL, unknown) adds.
module alu_ctrl_dec
  import mips_pkg::*;
(
  input  logic [5:0] ex_op,
  input  logic [5:0] ex_funct,
  output logic [2:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (ex_op)
      OP_RTYPE: begin
        case (ex_funct)
          FN_ADD, FN_ADDU: alu_ctrl = ALU_ADD;
          FN_SUB, FN_SUBU: alu_ctrl = ALU_SUB;
          FN_AND:          alu_ctrl = ALU_AND;
          FN_OR:           alu_ctrl = ALU_OR;
          FN_XOR:          alu_ctrl = ALU_XOR;
          FN_NOR:          alu_ctrl = ALU_NOR;
          FN_SLT:          alu_ctrl = ALU_SLT;
          default:         alu_ctrl = ALU_ADD;
        endcase
      end
      OP_BEQ, OP_BNE: alu_ctrl = ALU_SUB;
      default:        alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/exec_alu_bypass.sv
// Execute-stage ALU with registered zero/overflow flags, plus the ID-stage
// branch-operand bypass select logic driven from the EX/MEM and MEM/WB dests.
module exec_alu_bypass
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [5:0]    ex_op,
  input  logic [5:0]    ex_funct,
  input  logic [DW-1:0] alu_a,
  input  logic [DW-1:0] alu_b,
  output logic [2:0]    alu_ctrl,
  output logic [DW-1:0] alu_result,
  output logic          alu_zero,
  output logic          alu_zero_q,
  output logic          alu_ovf_q,
  input  logic [5:0]    id_op,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] exmem_dest,
  input  logic [RW-1:0] memwb_dest,
  output logic [1:0]    br_fwd_a,
  output logic [1:0]    br_fwd_b
);

  logic [DW-1:0] sum;
  logic [DW-1:0] diff;
  logic          slt;
  logic          alu_ovf_d;
  logic          alu_zero_d;

  alu_ctrl_dec u_dec (
    .ex_op    (ex_op),
    .ex_funct (ex_funct),
    .alu_ctrl (alu_ctrl)
  );

  assign sum  = alu_a + alu_b;
  assign diff = alu_a - alu_b;
  assign slt  = $signed(alu_a) < $signed(alu_b);

  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      ALU_ADD: alu_result = sum;
      ALU_XOR: alu_result = alu_a ^ alu_b;
      ALU_NOR: alu_result = ~(alu_a | alu_b);
      ALU_SUB: alu_result = diff;
      ALU_SLT: alu_result = {{(DW-1){1'b0}}, slt};
      default: alu_result = '0;
    endcase
  end

  assign alu_zero   = (alu_result == '0);
  assign alu_zero_d = alu_zero;

  // Signed overflow: operand signs agree (ADD) or differ (SUB) and the result sign flips.
  always_comb begin
    alu_ovf_d = 1'b0;
    case (alu_ctrl)
      ALU_ADD: alu_ovf_d = (alu_a[DW-1] == alu_b[DW-1]) && (sum[DW-1]  != alu_a[DW-1]);
      ALU_SUB: alu_ovf_d = (alu_a[DW-1] != alu_b[DW-1]) && (diff[DW-1] != alu_a[DW-1]);
      default: alu_ovf_d = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      alu_zero_q <= 1'b0;
      alu_ovf_q  <= 1'b0;
    end else begin
      alu_zero_q <= alu_zero_d;
      alu_ovf_q  <= alu_ovf_d;
    end
  end

  // EX/MEM is the younger producer, so it wins over MEM/WB; $0 is never bypassed.
  always_comb begin
    br_fwd_a = FWD_RF;
    br_fwd_b = FWD_RF;
    if (is_branch(id_op)) begin
      if (id_rs != '0 && id_rs == exmem_dest)      br_fwd_a = FWD_EXMEM;
      else if (id_rs != '0 && id_rs == memwb_dest) br_fwd_a = FWD_MEMWB;
      if (id_rt != '0 && id_rt == exmem_dest)      br_fwd_b = FWD_EXMEM;
      else if (id_rt != '0 && id_rt == memwb_dest) br_fwd_b = FWD_MEMWB;
    end
  end

endmodule

// File: tb/tb_exec_alu_bypass.sv
// Self-checking bench for exec_alu_bypass: directed ALU/decode/flag/bypass
// scenarios plus a random back-to-back run scored through expected queues.
module tb_exec_alu_bypass;

  logic        clock;
  logic        reset;
  logic [5:0]  ex_op, ex_funct, id_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_ctrl;
  logic        alu_zero, alu_zero_q, alu_ovf_q;
  logic [4:0]  id_rs, id_rt, exmem_dest, memwb_dest;
  logic [1:0]  br_fwd_a, br_fwd_b;

  logic [31:0] exp_q[$];
  logic [31:0] flag_q[$];
  logic [31:0] e;
  int          n_vec = 0;
  int          n_err = 0;

  exec_alu_bypass dut (
    .clock      (clock),
    .reset      (reset),
    .ex_op      (ex_op),
    .ex_funct   (ex_funct),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_zero_q (alu_zero_q),
    .alu_ovf_q  (alu_ovf_q),
    .id_op      (id_op),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .exmem_dest (exmem_dest),
    .memwb_dest (memwb_dest),
    .br_fwd_a   (br_fwd_a),
    .br_fwd_b   (br_fwd_b)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Driver tasks: inputs change on the falling edge, outputs sampled 1ns later.
  task automatic drive_alu(input logic [5:0] op, input logic [5:0] fn,
                           input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ex_op = op; ex_funct = fn; alu_a = a; alu_b = b;
    #1;
  endtask

  task automatic drive_br(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] exd, input logic [4:0] mwd);
    @(negedge clock);
    id_op = op; id_rs = rs; id_rt = rt; exmem_dest = exd; memwb_dest = mwd;
    #1;
  endtask

  // Reference model for the random run: {ovf, zero, result} packed into 34 bits.
  function automatic logic [2:0] model_ctrl(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'b000100 || op == 6'b000101) return 3'b110;
    if (op != 6'b000000) return 3'b010;
    case (fn)
      6'h22, 6'h23: return 3'b110;
      6'h24: return 3'b000;
      6'h25: return 3'b001;
      6'h26: return 3'b011;
      6'h27: return 3'b100;
      6'h2A: return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic logic [33:0] model_alu(input logic [2:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    logic        v;
    v = 1'b0;
    case (c)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b011: r = a ^ b;
      3'b100: r = ~(a | b);
      3'b111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b110: begin
        r = a - b;
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      default: begin
        r = a + b;
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
    endcase
    return {v, (r == 32'd0), r};
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    drive_alu(6'h00, 6'h20, 32'h7FFFFFFF, 32'd1);
    flag_q.push_back(32'd0);
    flag_q.push_back(32'd0);
    @(posedge clock); #1;
    e = flag_q.pop_front(); n_vec++;
    if ({31'd0, alu_zero_q} !== e) begin
      n_err++; $display("FAIL reset_zero_q got=%0b exp=%0d", alu_zero_q, e);
    end
    e = flag_q.pop_front(); n_vec++;
    if ({31'd0, alu_ovf_q} !== e) begin
      n_err++; $display("FAIL reset_ovf_q got=%0b exp=%0d", alu_ovf_q, e);
    end
    reset = 1'b0;
  endtask

  task automatic test_add;
    drive_alu(6'h00, 6'h20, 32'd7, 32'd5);
    exp_q.push_back(32'd2); exp_q.push_back(32'd12); exp_q.push_back(32'd0);
    e = exp_q.pop_front(); n_vec++;
    if ({29'd0, alu_ctrl} !== e) begin n_err++; $display("FAIL add_ctrl got=%0d exp=%0d", alu_ctrl, e); end
    e = exp_q.pop_front(); n_vec++;
    if (alu_result !== e) begin n_err++; $display("FAIL add_result got=%0d exp=%0d", alu_result, e); end
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, alu_zero} !== e) begin n_err++; $display("FAIL add_zero got=%0b exp=%0d", alu_zero, e); end
  endtask

  task automatic test_sub_zero;
    drive_alu(6'h00, 6'h22, 32'h1234, 32'h1234);
    exp_q.push_back(32'd6); exp_q.push_back(32'd0); exp_q.push_back(32'd1);
    flag_q.push_back(32'd1); flag_q.push_back(32'd0);
    e = exp_q.pop_front(); n_vec++;
    if ({29'd0, alu_ctrl} !== e) begin n_err++; $display("FAIL sub_ctrl got=%0d exp=%0d", alu_ctrl, e); end
    e = exp_q.pop_front(); n_vec++;
    if (alu_result !== e) begin n_err++; $display("FAIL sub_result got=%0h exp=%0h", alu_result, e); end
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, alu_zero} !== e) begin n_err++; $display("FAIL sub_zero got=%0b exp=%0d", alu_zero, e); end
    @(posedge clock); #1;
    e = flag_q.pop_front(); n_vec++;
    if ({31'd0, alu_zero_q} !== e) begin n_err++; $display("FAIL sub_zero_q got=%0b exp=%0d", alu_zero_q, e); end
    e = flag_q.pop_front(); n_vec++;
    if ({31'd0, alu_ovf_q} !== e) begin n_err++; $display("FAIL sub_ovf_q got=%0b exp=%0d", alu_ovf_q, e); end
  endtask

  task automatic test_overflow;
    // ADD overflow, then reset wins over a still-overflowing sample.
    drive_alu(6'h00, 6'h20, 32'h7FFFFFFF, 32'd1);
    exp_q.push_back(32'h80000000);
    flag_q.push_back(32'd1);
    e = exp_q.pop_front(); n_vec++;
    if (alu_result !== e) begin n_err++; $display("FAIL ovf_add_result got=%0h exp=%0h", alu_result, e); end
    @(posedge clock); #1;
    e = flag_q.pop_front(); n_vec++;
    if ({31'd0, alu_ovf_q} !== e) begin n_err++; $display("FAIL ovf_add_ovf_q got=%0b exp=%0d", alu_ovf_q, e); end
    @(negedge clock); reset = 1'b1;
    flag_q.push_back(32'd0); flag_q.push_back(32'd0); exp_q.push_back(32'h80000000);
    @(posedge clock); #1;
    e = flag_q.pop_front(); n_vec++;
    if ({31'd0, alu_ovf_q} !== e) begin n_err++; $display("FAIL rst_ovf_q got=%0b exp=%0d", alu_ovf_q, e); end
    e = flag_q.pop_front(); n_vec++;
    if ({31'd0, alu_zero_q} !== e) begin n_err++; $display("FAIL rst_zero_q got=%0b exp=%0d", alu_zero_q, e); end
    e = exp_q.pop_front(); n_vec++;
    if (alu_result !== e) begin n_err++; $display("FAIL rst_comb_result got=%0h exp=%0h", alu_result, e); end
    reset = 1'b0;
    // SUB overflow: most-negative minus one wraps positive.
    drive_alu(6'h00, 6'h23, 32'h80000000, 32'd1);
    exp_q.push_back(32'h7FFFFFFF); flag_q.push_back(32'd1);
    e = exp_q.pop_front(); n_vec++;
    if (alu_result !== e) begin n_err++; $display("FAIL ovf_sub_result got=%0h exp=%0h", alu_result, e); end
    @(posedge clock); #1;
    e = flag_q.pop_front(); n_vec++;
    if ({31'd0, alu_ovf_q} !== e) begin n_err++; $display("FAIL ovf_sub_ovf_q got=%0b exp=%0d", alu_ovf_q, e); end
  endtask

  task automatic test_logic_slt;
    logic [5:0]  fn_tab[6]  = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2A};
    logic [31:0] a_tab[6]   = '{32'hF0F000FF, 32'hF0F000FF, 32'hF0F000FF, 32'hF0F000FF,
                                32'hFFFFFFFF, 32'd1};
    logic [31:0] b_tab[6]   = '{32'h0FF00F0F, 32'h0FF00F0F, 32'h0FF00F0F, 32'h0FF00F0F,
                                32'd1, 32'hFFFFFFFF};
    logic [31:0] r_tab[6]   = '{32'h00F0000F, 32'hFFF00FFF, 32'hFF000FF0, 32'h000FF000,
                                32'd1, 32'd0};
    for (int i = 0; i < 6; i++) begin
      drive_alu(6'h00, fn_tab[i], a_tab[i], b_tab[i]);
      exp_q.push_back(r_tab[i]);
      e = exp_q.pop_front(); n_vec++;
      if (alu_result !== e) begin
        n_err++; $display("FAIL logic_result[%0d] got=%0h exp=%0h", i, alu_result, e);
      end
    end
  endtask

  task automatic test_decode;
    logic [5:0] op_tab[11] = '{6'b100011, 6'b000100, 6'b101011, 6'b001000, 6'b000101,
                               6'b000010, 6'b000011, 6'b000000, 6'b000000, 6'b000000,
                               6'b111111};
    logic [5:0] fn_tab[11] = '{6'h24, 6'h24, 6'h2A, 6'h22, 6'h24, 6'h22, 6'h27, 6'h08,
                               6'h21, 6'h23, 6'h22};
    logic [2:0] c_tab[11]  = '{3'b010, 3'b110, 3'b010, 3'b010, 3'b110, 3'b010, 3'b010,
                               3'b010, 3'b010, 3'b110, 3'b010};
    for (int i = 0; i < 11; i++) begin
      drive_alu(op_tab[i], fn_tab[i], 32'd9, 32'd4);
      exp_q.push_back({29'd0, c_tab[i]});
      e = exp_q.pop_front(); n_vec++;
      if ({29'd0, alu_ctrl} !== e) begin
        n_err++; $display("FAIL decode[%0d] got=%0b exp=%0b", i, alu_ctrl, e[2:0]);
      end
    end
  endtask

  task automatic test_bypass;
    logic [5:0] op_tab[8]  = '{6'b000100, 6'b000100, 6'b000100, 6'b001000, 6'b000101,
                               6'b000101, 6'b000100, 6'b000000};
    logic [4:0] rs_tab[8]  = '{5'd3, 5'd3, 5'd0, 5'd3, 5'd2, 5'd7, 5'd0, 5'd3};
    logic [4:0] rt_tab[8]  = '{5'd3, 5'd3, 5'd0, 5'd3, 5'd9, 5'd8, 5'd5, 5'd3};
    logic [4:0] ex_tab[8]  = '{5'd3, 5'd4, 5'd0, 5'd3, 5'd1, 5'd7, 5'd0, 5'd3};
    logic [4:0] mw_tab[8]  = '{5'd3, 5'd3, 5'd0, 5'd3, 5'd9, 5'd8, 5'd5, 5'd3};
    logic [3:0] f_tab[8]   = '{4'b1010, 4'b0101, 4'b0000, 4'b0000, 4'b0001, 4'b1001,
                               4'b0001, 4'b0000};
    for (int i = 0; i < 8; i++) begin
      drive_br(op_tab[i], rs_tab[i], rt_tab[i], ex_tab[i], mw_tab[i]);
      exp_q.push_back({28'd0, f_tab[i]});
      e = exp_q.pop_front(); n_vec++;
      if ({28'd0, br_fwd_a, br_fwd_b} !== e) begin
        n_err++;
        $display("FAIL bypass[%0d] got a=%0b b=%0b exp a=%0b b=%0b", i, br_fwd_a, br_fwd_b,
                 e[3:2], e[1:0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0]  ops[4] = '{6'b000000, 6'b000100, 6'b100011, 6'b001000};
    logic [5:0]  fns[9] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
    logic [5:0]  op, fn;
    logic [31:0] a, b;
    logic [33:0] m;
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 3)];
      fn = fns[$urandom_range(0, 8)];
      a = (i % 4 == 0) ? 32'h80000000 + $urandom_range(0, 3) : $urandom;
      b = (i % 5 == 0) ? a : $urandom;
      m = model_alu(model_ctrl(op, fn), a, b);
      drive_alu(op, fn, a, b);
      exp_q.push_back(m[31:0]);
      flag_q.push_back({30'd0, m[33], m[32]});
      e = exp_q.pop_front(); n_vec++;
      if (alu_result !== e) begin
        n_err++; $display("FAIL rand_result[%0d] got=%0h exp=%0h", i, alu_result, e);
      end
      @(posedge clock); #1;
      e = flag_q.pop_front(); n_vec++;
      if ({30'd0, alu_ovf_q, alu_zero_q} !== e) begin
        n_err++;
        $display("FAIL rand_flags[%0d] got ovf=%0b zero=%0b exp ovf=%0b zero=%0b", i,
                 alu_ovf_q, alu_zero_q, e[1], e[0]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    ex_op = '0; ex_funct = '0; alu_a = '0; alu_b = '0;
    id_op = '0; id_rs = '0; id_rt = '0; exmem_dest = '0; memwb_dest = '0;
    test_reset;
    test_add;
    test_sub_zero;
    test_overflow;
    test_logic_slt;
    test_decode;
    test_bypass;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
